// File: rtl/dmem_responder.sv
// Word-organised data memory sitting behind the MEM stage: byte-lane merged stores,
// lane-aligned loads, and a ready/error handshake with configurable wait states.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_write_data,
  input  logic        mem_write_en,
  input  logic        mem_read_en,
  input  logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_read_data,
  output logic        mem_ready,
  output logic        mem_error
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        r_state, w_next;
  logic [3:0]    r_cnt;
  logic [31:0]   r_addr, r_wdata, r_hold;
  logic [3:0]    r_mask;
  logic          r_re, r_we;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_req, w_err, w_oob, w_store_ok;
  logic [1:0]    w_off;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_wshift, w_load, w_resp_rd;

  // A mask is legal only as a byte, aligned halfword or aligned word that sits
  // on the lanes the address offset selects.
  function automatic logic mask_ok(input logic [3:0] m, input logic [1:0] off);
    case (m)
      4'b0001: return off == 2'd0;
      4'b0010: return off == 2'd1;
      4'b0100: return off == 2'd2;
      4'b1000: return off == 2'd3;
      4'b0011: return off == 2'd0;
      4'b1100: return off == 2'd2;
      4'b1111: return off == 2'd0;
      default: return 1'b0;
    endcase
  endfunction

  assign w_req      = mem_read_en | mem_write_en;
  assign w_off      = r_addr[1:0];
  assign w_idx      = r_addr[AW+1:2];
  assign w_oob      = |r_addr[31:AW+2];
  assign w_store_ok = mask_ok(r_mask, w_off);
  assign w_err      = w_oob | (r_re & r_we) | (r_we & ~w_store_ok);
  assign w_wshift   = r_wdata << {w_off, 3'b000};
  assign w_load     = r_mem[w_idx] >> {w_off, 3'b000};
  assign w_resp_rd  = w_err ? 32'd0 : w_load;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_hold  <= 32'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_req) r_cnt <= WS_INIT;
      else if (r_state == S_WAIT && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
      if (r_state == S_RESP && r_re) r_hold <= w_resp_rd;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_req) w_next = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
      S_WAIT: if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request capture: only IDLE listens to the bus.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && w_req) begin
      r_addr  <= mem_addr;
      r_wdata <= mem_write_data;
      r_mask  <= mem_byte_enable;
      r_re    <= mem_read_en;
      r_we    <= mem_write_en;
    end
  end

  // Commit the store at the end of RESP; a reset on that edge aborts it.
  always_ff @(posedge clk) begin
    if (rst_n && r_state == S_RESP && r_we && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (r_mask[i]) r_mem[w_idx][8*i +: 8] <= w_wshift[8*i +: 8];
      end
    end
  end

  assign mem_ready     = (r_state == S_RESP);
  assign mem_error     = (r_state == S_RESP) & w_err;
  assign mem_read_data = (r_state == S_RESP && r_re) ? w_resp_rd : r_hold;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with no wait states, one with three,
// expected responses queued at request time and compared when ready pulses.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr, wdata;
  logic        we, re;
  logic [3:0]  mask;
  int          sel;

  logic [31:0] rd0, rd3, rd;
  logic        rdy0, rdy3, rdy, err0, err3, err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] hold0 = 32'd0;
  logic [31:0] hold3 = 32'd0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .mem_addr(addr), .mem_write_data(wdata),
    .mem_write_en(we & (sel == 0)), .mem_read_en(re & (sel == 0)),
    .mem_byte_enable(mask), .mem_read_data(rd0), .mem_ready(rdy0), .mem_error(err0)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u3 (
    .clk(clk), .rst_n(rst_n), .mem_addr(addr), .mem_write_data(wdata),
    .mem_write_en(we & (sel == 3)), .mem_read_en(re & (sel == 3)),
    .mem_byte_enable(mask), .mem_read_data(rd3), .mem_ready(rdy3), .mem_error(err3)
  );

  assign rd  = (sel == 3) ? rd3 : rd0;
  assign rdy = (sel == 3) ? rdy3 : rdy0;
  assign err = (sel == 3) ? err3 : err0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One access on the selected instance; load_val is the value a clean load returns.
  task automatic acc(input int s, input bit r, input bit w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] m, input logic [31:0] load_val,
                     input bit exp_err, input bit scramble, input string tag);
    exp_t        e;
    exp_t        got;
    logic [31:0] h;
    int          cyc;
    int          ws;
    h  = (s == 3) ? hold3 : hold0;
    ws = s;
    e.rdata = r ? (exp_err ? 32'd0 : load_val) : h;
    e.err   = exp_err;
    e.tag   = tag;
    sb.push_back(e);
    if (s == 3) hold3 = e.rdata; else hold0 = e.rdata;
    sel = s; re = r; we = w; addr = a; wdata = d; mask = m;
    @(posedge clk); #1;
    re = 1'b0; we = 1'b0;
    cyc = 0;
    while (!rdy && cyc < 20) begin
      if (scramble) begin
        addr = $urandom; wdata = $urandom; mask = 4'($urandom);
        re = 1'($urandom); we = 1'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
    end
    re = 1'b0; we = 1'b0;
    got = sb.pop_front();
    chk({got.tag, "_latency"}, 32'(cyc), 32'(ws));
    chk({got.tag, "_ready"}, {31'd0, rdy}, 32'd1);
    chk({got.tag, "_error"}, {31'd0, err}, {31'd0, got.err});
    chk({got.tag, "_rdata"}, rd, got.rdata);
    @(posedge clk); #1;
    chk({got.tag, "_pulse"}, {30'd0, rdy, err}, 32'd0);
  endtask

  initial begin
    int pulses;
    sel = 0; re = 1'b0; we = 1'b0; addr = '0; wdata = '0; mask = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy0", {31'd0, rdy0}, 32'd0);
    chk("rst_err0", {31'd0, err0}, 32'd0);
    chk("rst_rd0", rd0, 32'd0);
    chk("rst_rdy3", {31'd0, rdy3}, 32'd0);
    chk("rst_err3", {31'd0, err3}, 32'd0);
    chk("rst_rd3", rd3, 32'd0);
    rst_n = 1'b1;

    acc(0, 0, 1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0, 0, 0, "sw10");
    acc(0, 1, 0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEEF, 0, 0, "lw10");
    acc(0, 0, 1, 32'h13, 32'h000000AA, 4'b1000, 32'h0, 0, 0, "sb13");
    acc(0, 1, 0, 32'h13, 32'h0, 4'b0000, 32'h000000AA, 0, 0, "lb13");
    acc(0, 1, 0, 32'h10, 32'h0, 4'b0000, 32'hAAADBEEF, 0, 0, "lw10_sb");
    acc(0, 0, 1, 32'h12, 32'h00001234, 4'b1100, 32'h0, 0, 0, "sh12");
    acc(0, 1, 0, 32'h12, 32'h0, 4'b0000, 32'h00001234, 0, 0, "lh12");
    acc(0, 1, 0, 32'h10, 32'h0, 4'b0000, 32'h1234BEEF, 0, 0, "lw10_sh");
    acc(0, 1, 0, 32'h11, 32'h0, 4'b0000, 32'h001234BE, 0, 0, "lb11");
    acc(0, 0, 1, 32'h0, 32'h0BADF00D, 4'b1111, 32'h0, 0, 0, "sw00");
    acc(0, 0, 1, 32'h1000, 32'h55555555, 4'b1111, 32'h0, 1, 0, "sw_oob");
    acc(0, 1, 0, 32'h0, 32'h0, 4'b0000, 32'h0BADF00D, 0, 0, "lw00_after_oob");
    acc(0, 0, 1, 32'h11, 32'h0000FFFF, 4'b0011, 32'h0, 1, 0, "sh_misalign");
    acc(0, 0, 1, 32'h10, 32'h000000FF, 4'b0101, 32'h0, 1, 0, "bad_mask");
    acc(0, 1, 1, 32'h10, 32'h0, 4'b1111, 32'h0, 1, 0, "rw_both");
    acc(0, 1, 0, 32'h10, 32'h0, 4'b0000, 32'h1234BEEF, 0, 0, "lw10_after_err");

    acc(3, 0, 1, 32'h20, 32'hCAFEF00D, 4'b1111, 32'h0, 0, 0, "ws_sw20");
    acc(3, 1, 0, 32'h20, 32'h0, 4'b0000, 32'hCAFEF00D, 0, 1, "ws_lw20_scr");
    acc(3, 1, 0, 32'h22, 32'h0, 4'b0000, 32'h0000CAFE, 0, 1, "ws_lh22_scr");

    // Reset lands in the middle of a store's wait states.
    sel = 3; we = 1'b1; addr = 32'h20; wdata = 32'h11111111; mask = 4'b1111;
    @(posedge clk); #1;
    we = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_rdy", {31'd0, rdy3}, 32'd0);
    chk("abort_err", {31'd0, err3}, 32'd0);
    chk("abort_rd", rd3, 32'd0);
    rst_n = 1'b1;
    hold0 = 32'd0; hold3 = 32'd0;
    pulses = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (rdy3) pulses++;
    end
    chk("abort_no_ready", 32'(pulses), 32'd0);
    acc(3, 1, 0, 32'h20, 32'h0, 4'b0000, 32'hCAFEF00D, 0, 0, "ws_lw20_after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder at the far end of the MEM-stage data-memory interface.
- Accepts the registered address, write data, read/write enables and byte-enable mask, and performs word-organised storage with byte-lane merging on stores.
- Returns lane-aligned read data so the MEM stage's sign/zero extension always operates on bits [7:0] / [15:0].
- Adds a ready/error handshake with configurable wait states, so pipeline stall logic can be exercised against a slow memory.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; word index = mem_addr[31:2]; must be a power of two ≥ 4.
- WAIT_STATES, 0: extra busy cycles inserted before mem_ready; 0..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- mem_addr  input  32  byte address of access.
- mem_write_data  input  32  store data, LSB-aligned (byte in [7:0], halfword in [15:0]).
- mem_write_en  input  1  store request (level).
- mem_read_en  input  1  load request (level).
- mem_byte_enable  input  4  lane mask for stores, already shifted by mem_addr[1:0]; ignored for loads.
- mem_read_data  output  32  load data, right-shifted by 8*addr[1:0], zero-filled above.
- mem_ready  output  1  one-cycle pulse: access complete.
- mem_error  output  1  valid with mem_ready: access rejected.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE, mem_ready=0, mem_error=0, mem_read_data=0, wait counter=0.
  - Storage array is not cleared.
  - Reset mid-access aborts the access: no write occurs and no ready is issued.
- FSM states IDLE, WAIT, RESP:
  - IDLE: if mem_read_en|mem_write_en, capture addr/data/enables/mask. Go to WAIT if WAIT_STATES>0 (counter=WAIT_STATES-1), else RESP. With no request, stay in IDLE.
  - WAIT: decrement counter; go to RESP when counter==0. Inputs are ignored while in WAIT.
  - RESP: perform the access on the captured request, drive mem_ready=1 for exactly this cycle, then return to IDLE.
- Latency: request seen in IDLE at edge N gives mem_ready high during cycle N+1+WAIT_STATES.
- Request signals are level-sensitive. A request still asserted when IDLE is re-entered starts a new access. Back-to-back throughput is therefore one access per (2+WAIT_STATES) cycles.
- Store, when no error:
  - Shifted data = mem_write_data << (8*addr[1:0]).
  - For each lane i with mask[i]=1, mem[idx][8i+7:8i] = shifted[8i+7:8i]. Other lanes are unchanged.
  - mem_read_data holds its previous value.
- Load, when no error:
  - mem_read_data = mem[idx] >> (8*addr[1:0]), upper bits zero.
  - The mask is not consulted.
- Error conditions (mem_error=1 with mem_ready; no storage change; on a load, mem_read_data=0):
  - word index ≥ DEPTH_WORDS, i.e. any address bit above log2(DEPTH_WORDS)+1 set;
  - mem_read_en and mem_write_en both high;
  - store with a mask not in {0001,0010,0100,1000,0011,1100,1111};
  - store whose mask does not match the address offset (halfword mask requires addr[0]=0; 1111 requires addr[1:0]=0; single-byte mask bit position must equal addr[1:0]).
- mem_error is 0 whenever mem_ready is 0.
- mem_read_data is stable outside RESP and is updated only in the RESP cycle of a load.

Test Plan:
- WAIT_STATES=0: SW addr 0x10 data 0xDEADBEEF mask 1111, then LW addr 0x10 → each ready one cycle after the request; read_data=0xDEADBEEF, error=0.
- SB addr 0x13 data 0x000000AA mask 1000 over word 0xDEADBEEF, then load addr 0x13 → word becomes 0xAAADBEEF; read_data=0x000000AA.
- SH addr 0x12 data 0x1234 mask 1100, then load addr 0x12 → read_data=0x00001234; load addr 0x10 → 0x1234BEEF.
- WAIT_STATES=3: single load → ready exactly 4 cycles after the request edge; inputs changed during WAIT have no effect.
- Errors:
  - store to word index DEPTH_WORDS → error=1, memory unchanged;
  - mask 0011 at addr 0x11 → error=1;
  - read_en and write_en both high → error=1, read_data=0.
- rst_n low during WAIT of a store → no ready pulse, target word unchanged, outputs zero next cycle; a subsequent load returns the old data.
